// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the mips-lite unified memory responder.
//   grant_e      : arbiter grant encoding (none / preload / data / fetch)
//   WORD_BYTES   : bytes per word
//   addr_legal   : word-aligned and fully inside the array
//   be_pack/unpack : big-endian byte <-> word conversion (byte 0 is the MSB)
package mips_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_D    = 2'd2,
        GNT_I    = 2'd3
    } grant_e;

    // Index 0 is the byte at the lowest address.
    typedef logic [WORD_BYTES-1:0][7:0] word_bytes_t;

    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - WORD_BYTES));
    endfunction

    function automatic logic [WORD_W-1:0] be_pack(input word_bytes_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic word_bytes_t be_unpack(input logic [WORD_W-1:0] w);
        word_bytes_t b;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        return b;
    endfunction

endpackage

// File: rtl/mips_mem_rsp_slot.sv
// Single-entry response holding register for one channel.
//   load_i       : capture data_i/err_i as a new response (request accepted)
//   rsp_ready_i  : initiator consumes the held response
//   rsp_valid_o/rsp_data_o/rsp_err_o : registered response
//   stall_c_o    : response pending and not consumed this cycle
module mips_mem_rsp_slot
    import mips_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              err_i,
    input  logic              rsp_ready_i,
    output logic              rsp_valid_o,
    output logic [WORD_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              stall_c_o
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    // Load takes priority; the top never loads while stalled.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            err_d   = err_i;
        end else if (valid_q && rsp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign stall_c_o   = valid_q && !rsp_ready_i;

endmodule

// File: rtl/mips_lite_mem_responder.sv
// Unified big-endian instruction/data memory for the mips-lite pipeline.
// One single-ported byte array shared by a preload port, the fetch channel
// and the data channel; one access per cycle, latency-1 responses.
//   ld_*        : word preload (highest priority, illegal addresses dropped)
//   if_*        : fetch request/response channel
//   d_*         : load/store request/response channel
//   rd_count    : accepted legal reads (fetch + load)
//   wr_count    : accepted legal stores
module mips_lite_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = 4096,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [7:0] mem [MEM_BYTES];

    grant_e      grant_d, next_grant_q;
    logic [SW-1:0] starve_q, starve_d;
    logic        d_we_q;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    logic        i_stall, d_stall;
    logic        i_fav;
    logic [31:0] acc_addr;
    logic        acc_legal;
    logic [AW-1:0] acc_base;
    word_bytes_t rd_bytes;
    word_bytes_t wr_bytes;
    logic [31:0] rd_word;
    logic        mem_we;
    logic        i_load, d_load;
    logic [31:0] i_load_data, d_load_data;

    // Arbiter: next-state grant, readies and starvation counter.
    always_comb begin
        grant_d       = GNT_NONE;
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        starve_d      = starve_q;
        i_fav         = (starve_q == SW'(STARVE_LIMIT));

        if (ld_en) begin
            grant_d = GNT_LD;
        end else if (rst_n) begin
            // Data yields only when fetch is favoured and could actually go.
            d_req_ready  = !d_stall && !(i_fav && if_req_valid && !i_stall);
            if_req_ready = !i_stall && (i_fav || !(d_req_valid && !d_stall));
            if (d_req_valid && d_req_ready) begin
                grant_d = GNT_D;
            end else if (if_req_valid && if_req_ready) begin
                grant_d = GNT_I;
            end
        end

        // Only a denial caused by data winning counts toward starvation.
        if (!if_req_valid || grant_d == GNT_I) begin
            starve_d = '0;
        end else if (grant_d == GNT_D && !i_stall && !i_fav) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Shared array port: address, read word, write enable and write bytes.
    always_comb begin
        case (grant_d)
            GNT_LD:  acc_addr = ld_addr;
            GNT_I:   acc_addr = if_addr;
            default: acc_addr = d_addr;
        endcase
        acc_legal = addr_legal(acc_addr, MEM_BYTES);
        acc_base  = acc_addr[AW-1:0];
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
            rd_bytes[k] = mem[acc_base + AW'(k)];
        end
        rd_word  = be_pack(rd_bytes);
        wr_bytes = be_unpack((grant_d == GNT_LD) ? ld_data : d_wdata);
        mem_we   = acc_legal && ((grant_d == GNT_LD) || (grant_d == GNT_D && d_req_we));

        i_load      = (grant_d == GNT_I);
        d_load      = (grant_d == GNT_D);
        i_load_data = acc_legal ? rd_word : '0;
        d_load_data = (acc_legal && !d_req_we) ? rd_word : '0;
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < WORD_BYTES; k++) begin
                mem[acc_base + AW'(k)] <= wr_bytes[k];
            end
        end
    end

    // Counters follow the response slot: the cycle after a grant the slot
    // holds that access's err flag, so legality is read from it.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (next_grant_q == GNT_I && !if_rsp_err) begin
            rd_count_d = rd_count_q + 32'd1;
        end else if (next_grant_q == GNT_D && !d_rsp_err) begin
            if (d_we_q) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_grant_q <= GNT_NONE;
            starve_q     <= '0;
            d_we_q       <= 1'b0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            next_grant_q <= grant_d;
            starve_q     <= starve_d;
            d_we_q       <= d_req_we;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

    mips_mem_rsp_slot u_if_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (i_load),
        .data_i      (i_load_data),
        .err_i       (!acc_legal),
        .rsp_ready_i (if_rsp_ready),
        .rsp_valid_o (if_rsp_valid),
        .rsp_data_o  (if_rsp_data),
        .rsp_err_o   (if_rsp_err),
        .stall_c_o   (i_stall)
    );

    mips_mem_rsp_slot u_d_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (d_load),
        .data_i      (d_load_data),
        .err_i       (!acc_legal),
        .rsp_ready_i (d_rsp_ready),
        .rsp_valid_o (d_rsp_valid),
        .rsp_data_o  (d_rsp_rdata),
        .rsp_err_o   (d_rsp_err),
        .stall_c_o   (d_stall)
    );

endmodule

// File: doc/mips_lite_mem_responder.md
Name: mips_lite_mem_responder

Overview:
- Byte-addressed, big-endian unified instruction/data memory that services the pipeline's fetch stage and memory stage.
- Fetch and memory stages act as initiators; this block is the responder.
- Two request/response channels share one single-ported array, with fixed-priority arbitration plus a starvation guard.
- A word-wide preload port fills the memory image before the pipeline starts.

Parameters:
- MEM_BYTES, 4096: array size in bytes; must be a multiple of 4 and a power of 2.
- STARVE_LIMIT, 4: consecutive fetch denials before fetch is granted priority for one cycle.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ld_en  in  1  preload word write.
- ld_addr  in  32  preload byte address, word-aligned.
- ld_data  in  32  preload word.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  32  fetch byte address (pc).
- if_rsp_valid  out  1  fetch response valid.
- if_rsp_ready  in  1  fetch initiator consumes response.
- if_rsp_data  out  32  instruction word.
- if_rsp_err  out  1  misaligned or out-of-range fetch.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted.
- d_req_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rsp_valid  out  1  data response valid; stores are acknowledged too.
- d_rsp_ready  in  1  data initiator consumes response.
- d_rsp_rdata  out  32  load data; 0 for stores.
- d_rsp_err  out  1  misaligned or out-of-range data access.
- rd_count  out  32  accepted reads (fetch + load).
- wr_count  out  32  accepted stores (preload excluded).

Behaviour:
- Clock is clk; reset rst_n is synchronous and active-low.
- Reset values:
  - all *_ready, *_rsp_valid, *_rsp_err, *_rsp_data/rdata, rd_count, wr_count and the starvation counter are 0.
  - Array contents are NOT cleared.
- Reset mid-operation: outstanding responses and the starvation counter are discarded. A store accepted before the reset edge has already committed; a request presented in the reset cycle is not accepted.
- Byte order: word at byte address A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}, with mem[A] driving bits [31:24].
- Legal access: addr[1:0] == 0 and addr <= MEM_BYTES-4. Anything else is an error response: err = 1, data = 0, no array write, counters unchanged.
- Handshake: a request is accepted in a cycle where valid && ready. The response appears with valid = 1 on the next cycle (latency 1) and holds data/err stable until rsp_valid && rsp_ready.
- A channel whose response is pending and not being consumed this cycle drives req_ready = 0. Back-to-back throughput is 1/cycle per channel when rsp_ready stays high.
- Arbitration (at most one array access per cycle), in priority order:
  - ld_en: writes ld_data (if legal; illegal preloads are silently dropped) and forces both req_ready = 0.
  - else data wins over fetch, unless starve_cnt == STARVE_LIMIT, in which case fetch wins that cycle.
  - starve_cnt increments when if_req_valid is denied only because data won; it clears on fetch accept or when if_req_valid is low; it saturates at STARVE_LIMIT.
- The arbiter FSM is visible in the next_grant register with states GNT_NONE, GNT_LD, GNT_D, GNT_I, re-evaluated every cycle from the rules above.
- Store: writes all 4 bytes at the accept edge. A load or fetch to the same address one cycle later returns the new data; there is no read-during-write window because only one access is allowed per cycle.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- ready is combinational from the pending flags, ld_en and arbitration. There is no combinational path from req_valid to rsp_*.

Decomposition:
- Shared package mips_mem_pkg holds:
  - typedef grant_e {GNT_NONE, GNT_LD, GNT_D, GNT_I}.
  - WORD_BYTES = 4.
  - function addr_legal(addr, mem_bytes).
  - function be_pack / be_unpack for big-endian byte↔word conversion.
- One natural sub-module, mips_mem_rsp_slot: a single-entry response holding register with valid/ready, data, err and pending flag, instantiated once per channel.
- Array, arbiter and counters stay in the top module.

Test Plan:
- Preload 0x20010005 at ld_addr 0x0. Fetch 0x0 → if_rsp_data = 0x20010005 one cycle after accept; mem[0] = 0x20 (MSB).
- Store d_wdata 0xDEADBEEF to 0x100, then load 0x100 → d_rsp_rdata = 0xDEADBEEF; wr_count = 1, rd_count = 1.
- Simultaneous fetch 0x4 and load 0x8 every cycle with STARVE_LIMIT = 4 → data granted 4 cycles, fetch granted on the 5th; starve_cnt returns to 0.
- Load 0x102 and fetch MEM_BYTES-2 → both err = 1, data = 0; counters unchanged; array untouched.
- Hold if_rsp_ready = 0 for 3 cycles after a fetch → if_rsp_valid/data stable, if_req_ready = 0 throughout; the next request is accepted in the cycle rsp_ready rises.
- Assert rst_n = 0 while d_rsp_valid = 1 → next cycle d_rsp_valid = 0, counters 0; preloaded word at 0x0 still reads 0x20010005.
